// File: rtl/mm_pkg.sv
// Shared sizing constants, FSM encoding and packing helper for the
// matrix-multiply scheduler.
package mm_pkg;

  localparam int ELEMENT_LENGTH = 32;
  localparam int NUM_ELEMENTS   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Element (row, col) sits at flat index row*n+col, with index 0 in the MSBs.
  function automatic int elemLsb(input int row, input int col, input int n, input int w);
    return (n * n - 1 - (row * n + col)) * w;
  endfunction

endpackage

// File: rtl/matmul_scheduler.sv
// Walks an N x N product in row-major order, handing one (row of A, column
// of B) pair at a time to an external inner_product and collecting results in C.
module matmul_scheduler #(
  parameter int ELEMENT_LENGTH = mm_pkg::ELEMENT_LENGTH,
  parameter int NUM_ELEMENTS   = mm_pkg::NUM_ELEMENTS
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_ELEMENTS*NUM_ELEMENTS*ELEMENT_LENGTH-1:0]   mat_a,
  input  logic [NUM_ELEMENTS*NUM_ELEMENTS*ELEMENT_LENGTH-1:0]   mat_b,
  input  logic                                                  mat_i_stb,
  output logic                                                  mat_i_ack,
  output logic [NUM_ELEMENTS*NUM_ELEMENTS*ELEMENT_LENGTH-1:0]   mat_c,
  output logic                                                  mat_c_o_stb,
  input  logic                                                  mat_c_o_ack,
  output logic [NUM_ELEMENTS*ELEMENT_LENGTH-1:0]                ip_row,
  output logic [NUM_ELEMENTS*ELEMENT_LENGTH-1:0]                ip_column,
  output logic                                                  ip_row_i_stb,
  output logic                                                  ip_column_i_stb,
  input  logic                                                  ip_row_i_ack,
  input  logic                                                  ip_column_i_ack,
  input  logic [ELEMENT_LENGTH-1:0]                             ip_out,
  input  logic                                                  ip_out_o_stb,
  output logic                                                  ip_out_o_ack,
  output logic                                                  busy
);
  import mm_pkg::*;

  localparam int W  = ELEMENT_LENGTH;
  localparam int N  = NUM_ELEMENTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST = idx_t'(N - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [N*N*W-1:0]   r_a;
  logic [N*N*W-1:0]   r_b;
  logic [N*N*W-1:0]   r_c;
  idx_t               r_i;
  idx_t               r_j;
  logic               r_row_stb;
  logic               r_col_stb;
  logic               r_live;
  logic               w_accept;
  logic               w_row_done;
  logic               w_col_done;
  logic               w_res;
  logic               w_last;
  logic [N*W-1:0]     w_column;

  // r_live holds mat_i_ack low until the first clock edge after reset release.
  assign mat_i_ack       = r_live & (r_state == IDLE);
  assign ip_out_o_ack    = (r_state == WAIT_RES);
  assign mat_c_o_stb     = (r_state == DONE);
  assign busy            = (r_state != IDLE);
  assign ip_row_i_stb    = r_row_stb;
  assign ip_column_i_stb = r_col_stb;
  assign mat_c           = r_c;

  assign w_accept   = mat_i_stb & mat_i_ack;
  assign w_row_done = ~r_row_stb | ip_row_i_ack;
  assign w_col_done = ~r_col_stb | ip_column_i_ack;
  assign w_res      = ip_out_o_stb & ip_out_o_ack;
  assign w_last     = (r_i == LAST) && (r_j == LAST);

  // Row i of A is already contiguous in the row-major flat operand.
  assign ip_row = r_a[(N - 1 - int'(r_i)) * N * W +: N * W];

  always_comb begin
    w_column = '0;
    for (int k = 0; k < N; k++) begin
      w_column[(N - 1 - k) * W +: W] = r_b[elemLsb(k, int'(r_j), N, W) +: W];
    end
  end
  assign ip_column = w_column;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next_state = ISSUE;
      ISSUE:    if (w_row_done && w_col_done) w_next_state = WAIT_RES;
      WAIT_RES: if (w_res) w_next_state = w_last ? DONE : ISSUE;
      DONE:     if (mat_c_o_ack) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Operand capture, per-channel strobes, (i,j) walk and result write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_row_stb <= 1'b0;
      r_col_stb <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a       <= mat_a;
            r_b       <= mat_b;
            r_i       <= '0;
            r_j       <= '0;
            r_row_stb <= 1'b1;
            r_col_stb <= 1'b1;
          end
        end
        ISSUE: begin
          if (ip_row_i_ack)    r_row_stb <= 1'b0;
          if (ip_column_i_ack) r_col_stb <= 1'b0;
        end
        WAIT_RES: begin
          if (w_res) begin
            r_c[elemLsb(int'(r_i), int'(r_j), N, W) +: W] <= ip_out;
            if (!w_last) begin
              r_row_stb <= 1'b1;
              r_col_stb <= 1'b1;
              if (r_j == LAST) begin
                r_j <= '0;
                r_i <= r_i + idx_t'(1);
              end else begin
                r_j <= r_j + idx_t'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler: a behavioural inner_product with
// adjustable handshake delays drives table-driven, corner-case and random jobs.
module tb_matmul_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int VW = N * W;
  localparam int MW = N * N * W;

  typedef int intMat_t [16];

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [MW-1:0] expC;
    int            rowDelay;
    int            colDelay;
    int            expLat;
    bit            chkWidth;
    string         name;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [MW-1:0] mat_a;
  logic [MW-1:0] mat_b;
  logic          mat_i_stb;
  logic          mat_i_ack;
  logic [MW-1:0] mat_c;
  logic          mat_c_o_stb;
  logic          mat_c_o_ack;
  logic [VW-1:0] ip_row;
  logic [VW-1:0] ip_column;
  logic          ip_row_i_stb;
  logic          ip_column_i_stb;
  logic          ip_row_i_ack;
  logic          ip_column_i_ack;
  logic [W-1:0]  ip_out;
  logic          ip_out_o_stb;
  logic          ip_out_o_ack;
  logic          busy;

  int checks = 0;
  int errors = 0;

  int rowDelay = 0;
  int colDelay = 0;
  int resDelay = 0;
  bit randMode = 0;
  bit junkStb  = 0;
  int rowWait, colWait, resWait, rowHigh, colHigh;
  logic [VW-1:0] curRow, curCol;
  logic [VW-1:0] rowQ[$];
  logic [VW-1:0] colQ[$];
  int rowHighQ[$];
  int colHighQ[$];
  int acceptCount = 0;
  int ackBusyBad  = 0;

  matmul_scheduler #(.ELEMENT_LENGTH(W), .NUM_ELEMENTS(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .mat_a           (mat_a),
    .mat_b           (mat_b),
    .mat_i_stb       (mat_i_stb),
    .mat_i_ack       (mat_i_ack),
    .mat_c           (mat_c),
    .mat_c_o_stb     (mat_c_o_stb),
    .mat_c_o_ack     (mat_c_o_ack),
    .ip_row          (ip_row),
    .ip_column       (ip_column),
    .ip_row_i_stb    (ip_row_i_stb),
    .ip_column_i_stb (ip_column_i_stb),
    .ip_row_i_ack    (ip_row_i_ack),
    .ip_column_i_ack (ip_column_i_ack),
    .ip_out          (ip_out),
    .ip_out_o_stb    (ip_out_o_stb),
    .ip_out_o_ack    (ip_out_o_ack),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer-valued single-precision encode/decode, exact for the small values used here.
  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 24; b++) if ((v >> b) != 0) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [MW-1:0] packInts(input intMat_t m);
    logic [MW-1:0] p;
    for (int f = 0; f < N * N; f++) p[(N * N - 1 - f) * W +: W] = i2f(m[f]);
    return p;
  endfunction

  function automatic logic [VW-1:0] rowOf(input logic [MW-1:0] m, input int i);
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[(N - 1 - k) * W +: W] = m[(N * N - 1 - (i * N + k)) * W +: W];
    return r;
  endfunction

  function automatic logic [VW-1:0] colOf(input logic [MW-1:0] m, input int j);
    logic [VW-1:0] c;
    for (int k = 0; k < N; k++) c[(N - 1 - k) * W +: W] = m[(N * N - 1 - (k * N + j)) * W +: W];
    return c;
  endfunction

  function automatic logic [W-1:0] ipDot(input logic [VW-1:0] r, input logic [VW-1:0] c);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += f2i(r[(N - 1 - k) * W +: W]) * f2i(c[(N - 1 - k) * W +: W]);
    return i2f(s);
  endfunction

  task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural inner_product: per-channel ack delays, result on the first
  // eligible WAIT_RES cycle, optional junk result strobes outside WAIT_RES.
  initial begin : ipModel
    ip_row_i_ack = 1'b0;
    ip_column_i_ack = 1'b0;
    ip_out_o_stb = 1'b0;
    ip_out = '0;
    rowWait = 0; colWait = 0; resWait = 0; rowHigh = 0; colHigh = 0;
    curRow = '0; curCol = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ip_row_i_ack = 1'b0;
        ip_column_i_ack = 1'b0;
        ip_out_o_stb = 1'b0;
        rowWait = 0; colWait = 0; resWait = 0; rowHigh = 0; colHigh = 0;
      end else begin
        if (ip_row_i_stb) begin
          rowHigh++;
          if (rowWait >= rowDelay) begin
            ip_row_i_ack = 1'b1;
            rowQ.push_back(ip_row);
            rowHighQ.push_back(rowHigh);
            curRow = ip_row;
            rowWait = 0;
            rowHigh = 0;
            if (randMode) rowDelay = int'($urandom_range(0, 3));
          end else begin
            ip_row_i_ack = 1'b0;
            rowWait++;
          end
        end else begin
          ip_row_i_ack = randMode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (ip_column_i_stb) begin
          colHigh++;
          if (colWait >= colDelay) begin
            ip_column_i_ack = 1'b1;
            colQ.push_back(ip_column);
            colHighQ.push_back(colHigh);
            curCol = ip_column;
            colWait = 0;
            colHigh = 0;
            if (randMode) colDelay = int'($urandom_range(0, 3));
          end else begin
            ip_column_i_ack = 1'b0;
            colWait++;
          end
        end else begin
          ip_column_i_ack = randMode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (ip_out_o_ack) begin
          if (resWait >= resDelay) begin
            ip_out_o_stb = 1'b1;
            ip_out = ipDot(curRow, curCol);
            resWait = 0;
            if (randMode) resDelay = int'($urandom_range(0, 2));
          end else begin
            ip_out_o_stb = 1'b0;
            resWait++;
          end
        end else begin
          resWait = 0;
          ip_out_o_stb = junkStb ? 1'($urandom_range(0, 1)) : 1'b0;
          ip_out = $urandom;
        end
      end
    end
  end

  initial begin : handshakeMonitor
    forever begin
      @(negedge clk);
      if (rst && mat_i_stb && mat_i_ack) acceptCount++;
      if (busy && mat_i_ack) ackBusyBad++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit hold);
    int n;
    rowQ.delete(); colQ.delete(); rowHighQ.delete(); colHighQ.delete();
    @(posedge clk); #1;
    mat_a = a;
    mat_b = b;
    mat_i_stb = 1'b1;
    n = 0;
    while (!mat_i_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", mat_i_ack, 1);
    @(posedge clk); #1;
    if (!hold) begin
      mat_i_stb = 1'b0;
      mat_a = ~a;
      mat_b = ~b;
    end
  endtask

  // Latency counts the mat_i transfer edge as edge 1.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!mat_c_o_stb && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("result_ready", mat_c_o_stb, 1);
  endtask

  task automatic drainDone(input int stall);
    logic [MW-1:0] held;
    int bad;
    held = mat_c;
    bad = 0;
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        if (!mat_c_o_stb || mat_c !== held) bad++;
      end
      checkOutput("done_stall_stable", bad, 0);
      @(negedge clk);
      mat_c_o_ack = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput("done_to_idle", {busy, mat_c_o_stb}, 0);
    checkOutput("c_held_in_idle", mat_c, held);
  endtask

  task automatic checkLog(input string name, input logic [MW-1:0] a, input logic [MW-1:0] b);
    int bad;
    bad = 0;
    checkOutput({name, "_row_xfers"}, rowQ.size(), N * N);
    checkOutput({name, "_col_xfers"}, colQ.size(), N * N);
    for (int p = 0; p < rowQ.size() && p < N * N; p++) if (rowQ[p] !== rowOf(a, p / N)) bad++;
    for (int p = 0; p < colQ.size() && p < N * N; p++) if (colQ[p] !== colOf(b, p % N)) bad++;
    checkOutput({name, "_xfer_order"}, bad, 0);
  endtask

  initial begin : main
    vec_t vecs[3];
    intMat_t ident, twos, ones, threes, ra, rb, rc;
    int lat;
    int bad;
    int stall;
    bit found;

    rst = 1'b0;
    mat_a = '0;
    mat_b = '0;
    mat_i_stb = 1'b0;
    mat_c_o_ack = 1'b1;
    for (int f = 0; f < N * N; f++) begin
      ident[f]  = (f / N == f % N) ? 1 : 0;
      twos[f]   = 2;
      ones[f]   = 1;
      threes[f] = 3;
    end
    vecs[0] = '{packInts(ident), packInts(twos), {16{32'h40000000}}, 0, 0, 33, 1'b0, "ident_x_twos"};
    vecs[1] = '{packInts(ident), packInts(twos), {16{32'h40000000}}, 0, 3, 0, 1'b1, "late_column"};
    vecs[2] = '{packInts(ones), packInts(threes), {16{32'h41400000}}, 0, 0, 33, 1'b0, "ones_x_threes"};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {mat_i_ack, busy, ip_row_i_stb, ip_column_i_stb, ip_out_o_ack, mat_c_o_stb}, 0);
    checkOutput("reset_mat_c", mat_c, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("ack_before_first_edge", mat_i_ack, 0);
    @(posedge clk); #1;
    checkOutput("ack_after_first_edge", mat_i_ack, 1);

    for (int v = 0; v < 3; v++) begin
      rowDelay = vecs[v].rowDelay;
      colDelay = vecs[v].colDelay;
      resDelay = 0;
      randMode = 1'b0;
      junkStb = 1'b0;
      mat_c_o_ack = 1'b1;
      applyStimulus(vecs[v].a, vecs[v].b, 1'b0);
      waitResult(lat);
      if (vecs[v].expLat != 0) checkOutput({vecs[v].name, "_latency"}, lat, vecs[v].expLat);
      checkOutput({vecs[v].name, "_c"}, mat_c, vecs[v].expC);
      drainDone(0);
      checkLog(vecs[v].name, vecs[v].a, vecs[v].b);
      if (vecs[v].chkWidth) begin
        bad = 0;
        foreach (rowHighQ[p]) if (rowHighQ[p] != 1) bad++;
        foreach (colHighQ[p]) if (colHighQ[p] != 4) bad++;
        checkOutput("strobe_widths", bad, 0);
      end
    end

    $display("[TB] stalled DONE handshake");
    rowDelay = 0; colDelay = 0; resDelay = 0;
    mat_c_o_ack = 1'b0;
    applyStimulus(packInts(ident), packInts(twos), 1'b0);
    waitResult(lat);
    checkOutput("stall_c", mat_c, {16{32'h40000000}});
    drainDone(10);

    $display("[TB] reset during WAIT_RES of element (1,2)");
    mat_c_o_ack = 1'b1;
    applyStimulus(packInts(ident), packInts(twos), 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk); #2;
      if (rowQ.size() == 7 && ip_out_o_ack) found = 1'b1;
    end
    checkOutput("reached_wait_res_1_2", found, 1);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {mat_i_ack, busy, ip_row_i_stb, ip_column_i_stb, ip_out_o_ack, mat_c_o_stb}, 0);
    checkOutput("async_reset_mat_c", mat_c, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(packInts(ones), packInts(threes), 1'b0);
    waitResult(lat);
    checkOutput("post_reset_c", mat_c, {16{32'h41400000}});
    drainDone(0);

    $display("[TB] mat_i_stb held high across jobs");
    acceptCount = 0;
    ackBusyBad = 0;
    applyStimulus(packInts(ones), packInts(twos), 1'b1);
    waitResult(lat);
    checkOutput("hold_first_c", mat_c, {16{32'h41000000}});
    drainDone(0);
    checkOutput("hold_one_accept", acceptCount, 1);
    @(posedge clk); #1;
    checkOutput("hold_reaccept_busy", busy, 1);
    mat_i_stb = 1'b0;
    waitResult(lat);
    checkOutput("hold_second_c", mat_c, {16{32'h41000000}});
    drainDone(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_two_accepts", acceptCount, 2);
    checkOutput("hold_ack_low_while_busy", ackBusyBad, 0);

    $display("[TB] randomized jobs");
    randMode = 1'b1;
    junkStb = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int f = 0; f < N * N; f++) begin
        ra[f] = int'($urandom_range(0, 7));
        rb[f] = int'($urandom_range(0, 7));
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          rc[i * N + j] = 0;
          for (int k = 0; k < N; k++) rc[i * N + j] += ra[i * N + k] * rb[k * N + j];
        end
      end
      stall = int'($urandom_range(0, 3));
      mat_c_o_ack = (stall == 0);
      rowDelay = int'($urandom_range(0, 3));
      colDelay = int'($urandom_range(0, 3));
      resDelay = int'($urandom_range(0, 2));
      applyStimulus(packInts(ra), packInts(rb), 1'b0);
      waitResult(lat);
      checkOutput($sformatf("rand%0d_c", r), mat_c, packInts(rc));
      drainDone(stall);
      checkLog($sformatf("rand%0d", r), packInts(ra), packInts(rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_scheduler.md
MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 SHALL have parameter ELEMENT_LENGTH, default 32, meaning IEEE-754 single-precision element width.
REQ-002 SHALL have parameter NUM_ELEMENTS, default 4, meaning matrix dimension N (square N x N operands).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mat_a  in  N*N*W  matrix A, row-major.
- mat_b  in  N*N*W  matrix B, row-major.
- mat_i_stb  in  1  A and B valid.
- mat_i_ack  out  1  A and B accepted.
- mat_c  out  N*N*W  result C, row-major.
- mat_c_o_stb  out  1  C valid.
- mat_c_o_ack  in  1  C consumed.
- ip_row  out  N*W  row vector to inner_product.
- ip_column  out  N*W  column vector to inner_product.
- ip_row_i_stb  out  1  row valid.
- ip_column_i_stb  out  1  column valid.
- ip_row_i_ack  in  1  row taken.
- ip_column_i_ack  in  1  column taken.
- ip_out  in  W  dot-product result.
- ip_out_o_stb  in  1  result valid.
- ip_out_o_ack  out  1  result taken.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 SHALL pack element (r,c) at flat index r*N+c, with index 0 in the MSBs.
REQ-005 SHALL pack vectors so that element k occupies bits [(N-1-k)*W +: W].
REQ-006 SHALL drive ip_row element k = A(i,k) and ip_column element k = B(k,j) for the current (i,j).
REQ-007 SHALL implement the states IDLE, ISSUE, WAIT_RES and DONE.
REQ-008 SHALL define a transfer on any channel as stb and ack both high at a rising clk edge.
REQ-009 IDLE: mat_i_ack = 1; on a mat_i transfer, SHALL register A and B, set i=j=0, and enter ISSUE.
REQ-010 ISSUE: on entry SHALL assert ip_row_i_stb and ip_column_i_stb.
REQ-011 ISSUE: SHALL drop each strobe independently on its own transfer.
REQ-012 ISSUE: SHALL enter WAIT_RES once both vectors have transferred, whether in the same cycle or in different cycles.
REQ-013 WAIT_RES: SHALL hold ip_out_o_ack = 1.
REQ-014 WAIT_RES: on an ip_out transfer, SHALL write ip_out into C(i,j).
REQ-015 WAIT_RES: after the write, SHALL enter DONE if (i,j) = (N-1,N-1); otherwise it SHALL advance j (wrapping j to 0 and incrementing i when j = N-1) and re-enter ISSUE.
REQ-016 DONE: SHALL hold mat_c_o_stb = 1 and mat_c stable until a mat_c_o transfer, then enter IDLE.
REQ-017 If mat_c_o_ack is already high on DONE entry, the transfer SHALL occur in the first DONE cycle.
REQ-018 SHALL issue products strictly in order (0,0),(0,1)..(N-1,N-1), with exactly N*N row and N*N column transfers per job.
REQ-019 SHALL hold ip_row and ip_column stable while either strobe is high.
REQ-020 SHALL ignore ip_out_o_stb outside WAIT_RES.
REQ-021 SHALL ignore mat_i_stb outside IDLE.
REQ-022 SHALL hold mat_c at its last value after a DONE-to-IDLE transition until the next write.
REQ-023 Timing with an inner_product that acks immediately and asserts ip_out_o_stb in the first WAIT_RES cycle: 2 cycles per element, and mat_c_o_stb SHALL rise 2*N*N+1 cycles after the mat_i transfer edge (33 for N=4).

Reset
REQ-024 While rst = 0, SHALL force: state IDLE; i=j=0; all strobes 0; ip_out_o_ack 0; busy 0; mat_c 0; mat_i_ack 0.
REQ-025 SHALL abort any job immediately on reset assertion, including mid-ISSUE and mid-WAIT_RES.
REQ-026 SHALL drive mat_i_ack = 1 from the first rising clk edge after rst is released.

Structure
REQ-027 SHALL define ELEMENT_LENGTH, NUM_ELEMENTS and the state encoding in shared package mm_pkg.
REQ-028 SHALL contain no sub-module.
REQ-029 The existing inner_product SHALL be instantiated beside this block by the top-level matrix_multiplier, not inside it.

Verification (bench models inner_product behaviourally; 1.0=3F800000, 2.0=40000000, 3.0=40400000)
REQ-030 SHALL cover: A = identity, B all 2.0, immediate-ack model -> C all 40000000, and mat_c_o_stb 33 cycles after the mat_i transfer.
REQ-031 SHALL cover: logging of every ip_row/ip_column transfer -> exactly 16 transfers each, in order (0,0)..(3,3), with row = A row i and column = B column j.
REQ-032 SHALL cover: ip_column_i_ack delayed 3 cycles after ip_row_i_ack -> ip_row_i_stb drops after 1 cycle, ip_column_i_stb holds 4 cycles, and C is unchanged versus REQ-030.
REQ-033 SHALL cover: mat_c_o_ack low for 10 cycles in DONE -> mat_c_o_stb and mat_c stable for all 10 cycles, then IDLE one cycle after ack.
REQ-034 SHALL cover: rst pulsed low during WAIT_RES of element (1,2) -> all outputs reach reset values asynchronously, and a new job (A all 1.0, B all 3.0) yields C all 41400000 (12.0).
REQ-035 SHALL cover: mat_i_stb held high through a whole job -> exactly one job is accepted per IDLE visit, and mat_i_ack is low while busy.
